// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every handshake/bus signal of the IF/MEM-to-RAM arbiter.
//   slave  : arbiter view (requests and RAM responses in; acks, read data and RAM strobes out)
//   master : requester/RAM-model view (the reverse directions)
//   Signals:
//     if_req/if_addr/if_rdata/if_ack                 instruction-fetch read port
//     m_req/m_we/m_type/m_addr/m_wdata               MEM-stage request
//     m_rdata/m_ack/m_err                            MEM-stage response
//     busy                                           arbiter not idle
//     ram_en/ram_we/ram_addr/ram_wdata               RAM request
//     ram_rdata/ram_ready                            RAM response
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ack;

    logic              m_req;
    logic              m_we;
    logic [2:0]        m_type;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;
    logic              m_ack;
    logic              m_err;

    logic              busy;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_ready;

    modport slave (
        input  if_req, if_addr, m_req, m_we, m_type, m_addr, m_wdata, ram_rdata, ram_ready,
        output if_rdata, if_ack, m_rdata, m_ack, m_err, busy, ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, m_req, m_we, m_type, m_addr, m_wdata, ram_rdata, ram_ready,
        input  if_rdata, if_ack, m_rdata, m_ack, m_err, busy, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported data RAM between the IF and MEM pipeline stages.
//   Arbitrates requests (MEM priority with an IF anti-starvation streak), sequences
//   each access over a ready-handshake RAM port, builds big-endian byte enables and
//   lane-replicated store data, and extracts/extends load data.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   mem_port_arbiter_if.slave (IF port, MEM port, busy, RAM port)
// Parameters:
//   ADDR_W      byte-address width
//   STARVE_LIM  consecutive MEM grants with IF waiting before IF is forced to win (1..15)
// Configuration:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned half/word and reserved type 11 return
//                       m_ack=m_err=1 without a RAM cycle; when undefined m_err=0, low
//                       address bits are ignored for half/word and type 11 acts as word.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_M, RESP} state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t            state_q;
    logic [3:0]        streak_q;
    logic              m_we_q;
    logic [1:0]        sz_q;
    logic              sext_q;
    logic [1:0]        lane_q;
    logic              ram_en_q;
    logic [3:0]        ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [31:0]       if_rdata_q;
    logic              if_ack_q;
    logic [31:0]       m_rdata_q;
    logic              m_ack_q;
`ifdef MEM_ALIGN_CHECK_EN
    logic              m_err_q;
    logic              misalign_d;
`endif

    logic              mem_wins_d;
    logic [3:0]        we_d;
    logic [31:0]       wdata_d;
    logic [31:0]       load_d;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              unused_if_lsb;

    assign unused_if_lsb = ^bus.if_addr[1:0];

    // Grant decode and store formatting from the live request (used only in IDLE).
    // Lane map is big-endian: addr 0 addresses bits [31:24].
    always_comb begin
        mem_wins_d = bus.m_req && !(bus.if_req && (streak_q == LIM));
        we_d       = 4'b1111;
        wdata_d    = bus.m_wdata;
        case (bus.m_type[1:0])
            2'b00: begin
                we_d    = 4'b1000 >> bus.m_addr[1:0];
                wdata_d = {4{bus.m_wdata[7:0]}};
            end
            2'b01: begin
                we_d    = bus.m_addr[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{bus.m_wdata[15:0]}};
            end
            default: begin
                we_d    = 4'b1111;
                wdata_d = bus.m_wdata;
            end
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        misalign_d = (bus.m_type[1:0] == 2'b11) ||
                     ((bus.m_type[1:0] == 2'b01) && bus.m_addr[0]) ||
                     ((bus.m_type[1:0] == 2'b10) && (bus.m_addr[1:0] != 2'b00));
`endif
    end

    // Load extraction from the RAM word using the access parameters latched at grant.
    always_comb begin
        case (lane_q)
            2'b00:   ld_byte = bus.ram_rdata[31:24];
            2'b01:   ld_byte = bus.ram_rdata[23:16];
            2'b10:   ld_byte = bus.ram_rdata[15:8];
            default: ld_byte = bus.ram_rdata[7:0];
        endcase
        ld_half = lane_q[1] ? bus.ram_rdata[15:0] : bus.ram_rdata[31:16];
        case (sz_q)
            2'b00:   load_d = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_d = {{16{sext_q & ld_half[15]}}, ld_half};
            default: load_d = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            m_we_q      <= 1'b0;
            sz_q        <= '0;
            sext_q      <= 1'b0;
            lane_q      <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            m_rdata_q   <= '0;
            m_ack_q     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            m_err_q     <= 1'b0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            m_ack_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            m_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mem_wins_d) begin
                        if (bus.if_req && (streak_q != 4'hF)) begin
                            streak_q <= streak_q + 4'd1;
                        end
                        m_we_q <= bus.m_we;
                        sz_q   <= bus.m_type[1:0];
                        sext_q <= bus.m_type[2];
                        lane_q <= bus.m_addr[1:0];
`ifdef MEM_ALIGN_CHECK_EN
                        if (misalign_d) begin
                            // Error completes straight from IDLE with no RAM cycle.
                            state_q   <= RESP;
                            m_ack_q   <= 1'b1;
                            m_err_q   <= 1'b1;
                            m_rdata_q <= '0;
                        end else begin
`else
                        begin
`endif
                            state_q     <= ACC_M;
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= bus.m_we ? we_d : 4'b0000;
                            ram_addr_q  <= {bus.m_addr[ADDR_W-1:2], 2'b00};
                            ram_wdata_q <= wdata_d;
                        end
                    end else if (bus.if_req) begin
                        streak_q    <= '0;
                        state_q     <= ACC_IF;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= 4'b0000;
                        ram_addr_q  <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        ram_wdata_q <= '0;
                    end
                end
                ACC_IF: begin
                    if (bus.ram_ready) begin
                        state_q     <= RESP;
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= '0;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= '0;
                        if_rdata_q  <= bus.ram_rdata;
                        if_ack_q    <= 1'b1;
                    end
                end
                ACC_M: begin
                    if (bus.ram_ready) begin
                        state_q     <= RESP;
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= '0;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= '0;
                        m_rdata_q   <= m_we_q ? 32'd0 : load_d;
                        m_ack_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    if_rdata_q <= '0;
                    m_rdata_q  <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.m_rdata   = m_rdata_q;
    assign bus.m_ack     = m_ack_q;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.m_err     = m_err_q;
`else
    assign bus.m_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter: reset, stores, signed/unsigned loads,
//   wait states, IF/MEM contention with starvation limit, alignment handling
//   (both MEM_ALIGN_CHECK_EN settings) and reset during an access.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .STARVE_LIM(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.m_req     = 1'b0;
        bus.m_we      = 1'b0;
        bus.m_type    = '0;
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.ram_rdata = '0;
        bus.ram_ready = 1'b0;
    endtask

    // Store with ram_ready=1: check RAM strobes in ACC, ack in RESP, back to idle.
    task automatic do_store(input string tag, input logic [2:0] ty, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] exp_we,
                            input logic [31:0] exp_wd, input logic [31:0] exp_a);
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_type = ty; bus.m_addr = a;
        bus.m_wdata = wd; bus.ram_ready = 1'b1;
        tick();
        chk({tag, "_we"},    {28'd0, bus.ram_we}, {28'd0, exp_we});
        chk({tag, "_wdata"}, bus.ram_wdata, exp_wd);
        chk({tag, "_addr"},  bus.ram_addr, exp_a);
        tick();
        chk({tag, "_ack"},   {31'd0, bus.m_ack}, 32'd1);
        idle_inputs();
        tick();
    endtask

    // Load with ram_ready=1 returning word rd; check extended result in RESP.
    task automatic do_load(input string tag, input logic [2:0] ty, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_type = ty; bus.m_addr = a;
        bus.ram_ready = 1'b1; bus.ram_rdata = rd;
        tick();
        chk({tag, "_we0"}, {28'd0, bus.ram_we}, 32'd0);
        tick();
        chk({tag, "_ack"},   {31'd0, bus.m_ack}, 32'd1);
        chk({tag, "_rdata"}, bus.m_rdata, exp);
        idle_inputs();
        tick();
        chk({tag, "_rdata_clr"}, bus.m_rdata, 32'd0);
    endtask

    initial begin
        logic exp_if [10];

        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        chk("rst_ram_en", {31'd0, bus.ram_en}, 32'd0);
        chk("rst_busy",   {31'd0, bus.busy},   32'd0);
        chk("rst_ack",    {30'd0, bus.if_ack, bus.m_ack}, 32'd0);
        chk("rst_err",    {31'd0, bus.m_err},  32'd0);
        chk("rst_we",     {28'd0, bus.ram_we}, 32'd0);
        rst = 1'b1;
        tick();

        // Store byte to 0x13, with input changes after grant that must be ignored.
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_type = 3'b000;
        bus.m_addr = 32'h13; bus.m_wdata = 32'hAB;
        tick();
        chk("sb_en",    {31'd0, bus.ram_en}, 32'd1);
        chk("sb_busy",  {31'd0, bus.busy},   32'd1);
        chk("sb_we",    {28'd0, bus.ram_we}, 32'h1);
        chk("sb_wdata", bus.ram_wdata, 32'hABABABAB);
        chk("sb_addr",  bus.ram_addr,  32'h10);
        bus.m_addr = 32'h0; bus.m_wdata = 32'h55; bus.ram_ready = 1'b1;
        tick();
        chk("sb_ack",    {31'd0, bus.m_ack},  32'd1);
        chk("sb_if_ack", {31'd0, bus.if_ack}, 32'd0);
        chk("sb_en_off", {31'd0, bus.ram_en}, 32'd0);
        idle_inputs();
        tick();
        chk("sb_ack_pulse", {31'd0, bus.m_ack}, 32'd0);
        chk("sb_idle",      {31'd0, bus.busy},  32'd0);

        do_store("sh2", 3'b001, 32'h22, 32'h0000BEEF, 4'b0011, 32'hBEEFBEEF, 32'h20);
        do_store("sh0", 3'b001, 32'h20, 32'h12345678, 4'b1100, 32'h56785678, 32'h20);
        do_store("sb0", 3'b000, 32'h40, 32'h000000C3, 4'b1000, 32'hC3C3C3C3, 32'h40);
        do_store("sw",  3'b010, 32'h44, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 32'h44);

        do_load("lhs", 3'b101, 32'h0, 32'h80FF1234, 32'hFFFF80FF);
        do_load("lhu", 3'b001, 32'h0, 32'h80FF1234, 32'h000080FF);
        do_load("lbs1", 3'b100, 32'h1, 32'h80FF1234, 32'hFFFFFFFF);
        do_load("lbu1", 3'b000, 32'h1, 32'h80FF1234, 32'h000000FF);
        do_load("lbs3", 3'b100, 32'h3, 32'h80FF1234, 32'h00000034);
        do_load("lhs2", 3'b101, 32'h2, 32'h80FF9234, 32'hFFFF9234);

        // IF fetch with three wait states.
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("ws_en",   {31'd0, bus.ram_en}, 32'd1);
            chk("ws_addr", bus.ram_addr, 32'h100);
            chk("ws_noack", {31'd0, bus.if_ack}, 32'd0);
            if (i == 3) begin
                bus.ram_ready = 1'b1; bus.ram_rdata = 32'hDEADBEEF;
            end
            if (i < 3) tick();
        end
        tick();
        chk("ws_ack",    {31'd0, bus.if_ack}, 32'd1);
        chk("ws_rdata",  bus.if_rdata, 32'hDEADBEEF);
        chk("ws_m_ack",  {31'd0, bus.m_ack}, 32'd0);
        chk("ws_m_rdata", bus.m_rdata, 32'd0);
        idle_inputs();
        tick();
        chk("ws_ack_pulse", {31'd0, bus.if_ack}, 32'd0);

        // Contention: both held high; expected grant order M,M,M,M,IF,M,M,M,M,IF.
        for (int i = 0; i < 10; i++) exp_if[i] = (i == 4) || (i == 9);
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_type = 3'b010; bus.m_addr = 32'h40;
        bus.ram_ready = 1'b1; bus.ram_rdata = 32'h0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ct_addr", bus.ram_addr, exp_if[i] ? 32'h200 : 32'h40);
            tick();
            chk("ct_ack", {30'd0, bus.if_ack, bus.m_ack}, exp_if[i] ? 32'd2 : 32'd1);
            tick();
        end
        idle_inputs();
        tick();

        // Misaligned word at 0x6.
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_type = 3'b010; bus.m_addr = 32'h6;
        bus.m_wdata = 32'h11223344; bus.ram_ready = 1'b1;
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        chk("ma_en",    {31'd0, bus.ram_en}, 32'd0);
        chk("ma_ack",   {31'd0, bus.m_ack},  32'd1);
        chk("ma_err",   {31'd0, bus.m_err},  32'd1);
        chk("ma_rdata", bus.m_rdata, 32'd0);
`else
        chk("ma_en",    {31'd0, bus.ram_en}, 32'd1);
        chk("ma_we",    {28'd0, bus.ram_we}, 32'hF);
        chk("ma_addr",  bus.ram_addr, 32'h4);
        chk("ma_wdata", bus.ram_wdata, 32'h11223344);
        tick();
        chk("ma_ack",   {31'd0, bus.m_ack}, 32'd1);
        chk("ma_err",   {31'd0, bus.m_err}, 32'd0);
`endif
        idle_inputs();
        tick();
        tick();

        // Reset during an access, then the held request is served normally.
        bus.m_req = 1'b1; bus.m_we = 1'b0; bus.m_type = 3'b010; bus.m_addr = 32'h80;
        bus.ram_ready = 1'b0; bus.ram_rdata = 32'h12345678;
        tick();
        chk("rm_en_pre", {31'd0, bus.ram_en}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rm_en",   {31'd0, bus.ram_en}, 32'd0);
        chk("rm_busy", {31'd0, bus.busy},   32'd0);
        chk("rm_ack",  {30'd0, bus.if_ack, bus.m_ack}, 32'd0);
        tick();
        rst = 1'b1;
        bus.ram_ready = 1'b1;
        tick();
        chk("rm_re_en",   {31'd0, bus.ram_en}, 32'd1);
        chk("rm_re_addr", bus.ram_addr, 32'h80);
        tick();
        chk("rm_re_ack",   {31'd0, bus.m_ack}, 32'd1);
        chk("rm_re_rdata", bus.m_rdata, 32'h12345678);
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
